// File: rtl/vector_valu_issue.sv
// Issue side of the VALU port: selects operands, tracks ops through the fixed-latency VALU,
// merges results with old vd under the lane mask and queues them toward writeback.
module vector_valu_issue #(
  parameter int NUM_ELEMENTS = 16,
  parameter int OP_W         = 5,
  parameter int IMM_W        = 16,
  parameter int TAG_W        = 5,
  parameter int VALU_LAT     = 2,
  parameter int OBUF_DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [OP_W-1:0]           in_vop,
  input  logic [16*NUM_ELEMENTS-1:0] in_v1,
  input  logic [16*NUM_ELEMENTS-1:0] in_v2,
  input  logic [31:0]               in_r1,
  input  logic [IMM_W-1:0]          in_imm,
  input  logic [1:0]                in_src2_sel,
  input  logic [NUM_ELEMENTS-1:0]   in_vmask,
  input  logic [16*NUM_ELEMENTS-1:0] in_vold,
  input  logic [TAG_W-1:0]          in_tag,
  output logic [16*NUM_ELEMENTS-1:0] valu_vdat1,
  output logic [16*NUM_ELEMENTS-1:0] valu_vdat2,
  output logic [OP_W-1:0]           valu_vop,
  output logic [NUM_ELEMENTS-1:0]   valu_vmask,
  input  logic [16*NUM_ELEMENTS-1:0] valu_result,
  output logic                      wb_valid,
  input  logic                      wb_ready,
  output logic [16*NUM_ELEMENTS-1:0] wb_vdata,
  output logic [TAG_W-1:0]          wb_tag,
  input  logic                      flush,
  input  logic                      err_clr,
  output logic                      busy,
  output logic [4:0]                error
);

  localparam int VW = 16 * NUM_ELEMENTS;
  localparam int NS = VALU_LAT + 1;
  localparam int PW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam int CW = $clog2(OBUF_DEPTH + VALU_LAT + 3);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(OBUF_DEPTH);

  function automatic logic [VW-1:0] bcast16(input logic [15:0] h);
    return {NUM_ELEMENTS{h}};
  endfunction

  function automatic logic [VW-1:0] merge_lanes(input logic [VW-1:0] res,
                                                input logic [VW-1:0] old,
                                                input logic [NUM_ELEMENTS-1:0] m);
    logic [VW-1:0] r;
    r = {VW{1'b0}};
    for (int i = 0; i < NUM_ELEMENTS; i++) begin
      r[16*i +: 16] = m[i] ? res[16*i +: 16] : old[16*i +: 16];
    end
    return r;
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(OBUF_DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  logic                    accept_s, legal_s, issue_s, push_s, pop_s, busy_s;
  logic [VW-1:0]           src2_s, push_data_s;
  logic [CW-1:0]           inflight_s;
  logic [CW:0]             credit_sum_s;
  logic                    issue_valid_r;
  logic [NS-1:0]           sh_valid_r;
  logic [TAG_W-1:0]        sh_tag_r  [NS];
  logic [NUM_ELEMENTS-1:0] sh_mask_r [NS];
  logic [VW-1:0]           sh_vold_r [NS];
  logic [VW-1:0]           fifo_data_r [OBUF_DEPTH];
  logic [TAG_W-1:0]        fifo_tag_r  [OBUF_DEPTH];
  logic [PW-1:0]           rd_ptr_r, wr_ptr_r;
  logic [CW-1:0]           fifo_cnt_r;
  logic [4:0]              error_r;
  logic                    unused_s;

  assign unused_s = ^in_r1[31:16];

  // Credit check and handshake; every slot in flight or queued counts against the FIFO depth.
  always_comb begin
    inflight_s   = CW'($countones(sh_valid_r));
    credit_sum_s = {1'b0, inflight_s} + {1'b0, fifo_cnt_r};
    in_ready     = !rst && !flush && (credit_sum_s < DEPTH_C);
    accept_s     = in_valid && in_ready;
    legal_s      = (in_src2_sel != 2'd3);
    issue_s      = accept_s && legal_s;
    push_s       = sh_valid_r[NS-1];
    pop_s        = wb_valid && wb_ready;
    busy_s       = issue_valid_r || (|sh_valid_r) || (fifo_cnt_r != {CW{1'b0}});
    push_data_s  = merge_lanes(valu_result, sh_vold_r[NS-1], sh_mask_r[NS-1]);
  end

  // Second-operand select.
  always_comb begin
    src2_s = {VW{1'b0}};
    case (in_src2_sel)
      2'd0:    src2_s = in_v2;
      2'd1:    src2_s = bcast16(in_r1[15:0]);
      2'd2:    src2_s = bcast16(in_imm[15:0]);
      default: src2_s = {VW{1'b0}};
    endcase
  end

  // Issue register: holds an op for exactly one cycle, zeros (NOP) otherwise.
  always_ff @(posedge clk) begin
    if (rst || flush || !issue_s) begin
      issue_valid_r <= 1'b0;
      valu_vdat1    <= {VW{1'b0}};
      valu_vdat2    <= {VW{1'b0}};
      valu_vop      <= {OP_W{1'b0}};
      valu_vmask    <= {NUM_ELEMENTS{1'b0}};
    end else begin
      issue_valid_r <= 1'b1;
      valu_vdat1    <= in_v1;
      valu_vdat2    <= src2_s;
      valu_vop      <= in_vop;
      valu_vmask    <= in_vmask;
    end
  end

  // Shadow pipe valid bits; the tail lines up with valu_result.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      sh_valid_r <= {NS{1'b0}};
    end else begin
      sh_valid_r[0] <= issue_s;
      for (int i = 1; i < NS; i++) sh_valid_r[i] <= sh_valid_r[i-1];
    end
  end

  // Shadow pipe payload (qualified by the valid bits).
  always_ff @(posedge clk) begin
    sh_tag_r[0]  <= in_tag;
    sh_mask_r[0] <= in_vmask;
    sh_vold_r[0] <= in_vold;
    for (int i = 1; i < NS; i++) begin
      sh_tag_r[i]  <= sh_tag_r[i-1];
      sh_mask_r[i] <= sh_mask_r[i-1];
      sh_vold_r[i] <= sh_vold_r[i-1];
    end
  end

  // Output FIFO storage.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_data_r[wr_ptr_r] <= push_data_s;
      fifo_tag_r[wr_ptr_r]  <= sh_tag_r[NS-1];
    end
  end

  // Output FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_r   <= {PW{1'b0}};
      wr_ptr_r   <= {PW{1'b0}};
      fifo_cnt_r <= {CW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= next_ptr(wr_ptr_r);
      if (pop_s)  rd_ptr_r <= next_ptr(rd_ptr_r);
      fifo_cnt_r <= fifo_cnt_r + CW'(push_s) - CW'(pop_s);
    end
  end

  // Sticky errors; a new set in the clearing cycle survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      error_r <= 5'b00000;
    end else begin
      error_r <= (err_clr ? 5'b00000 : error_r) |
                 {3'b000, flush && busy_s, accept_s && !legal_s};
    end
  end

  assign wb_valid = (fifo_cnt_r != {CW{1'b0}});
  assign wb_vdata = fifo_data_r[rd_ptr_r];
  assign wb_tag   = fifo_tag_r[rd_ptr_r];
  assign busy     = busy_s;
  assign error    = error_r;

endmodule
